btn_debounce: RTL

Debounces and synchronises the board push-buttons into clean per-button levels, single-cycle press pulses and a buffered, acknowledged press-event stream for the game controller. It runs in the core clock domain and is held in reset by `rst`, which comes from the clock-locked reset stage. Presses that arrive while the controller is busy are held in a per-button pending set, so no press is lost.

---
 rtl/btn_debounce.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Turns the raw board push-buttons into clean signals for the game controller.
// Each button is synchronised, debounced and reported in three ways:
//   - btn_level : the debounced level of each button.
//   - btn_press : a one-cycle pulse on each debounced rising edge.
//   - an event stream (evt_valid / evt_code / evt_ack) that reports presses
//     in fixed priority, lowest index first.
// A press that arrives while the controller is busy is held in a pending set,
// so it is not lost. A second press of a button that is already pending is
// merged into the pending entry, and evt_drop pulses to flag that.
//
// Ports
//   clk        in   core clock
//   rst        in   synchronous, active-high reset
//   btn_in     in   raw asynchronous buttons, active-high   [N_BTN]
//   btn_level  out  debounced level                         [N_BTN]
//   btn_press  out  one-cycle pulse on debounced 0->1        [N_BTN]
//   evt_valid  out  a press event is presented
//   evt_code   out  button index of the presented event     [CODE_W]
//   evt_ack    in   consumer accepts the presented event
//   evt_drop   out  one-cycle pulse when a press merges into a pending entry
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
//
// Event register states
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no event presented; load the lowest pending index if there is one
//   HOLD  | event presented, evt_code stable; on ack, load the next pending
//         | index or return to IDLE
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int N_BTN         = 5,
    parameter int CODE_W        = 3,
    parameter int STABLE_CYCLES = 650000,
    parameter int CNT_W         = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn_in,
    output logic [N_BTN-1:0]  btn_level,
    output logic [N_BTN-1:0]  btn_press,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    input  logic              evt_ack,
    output logic              evt_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } evt_state_e;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

    // Synchroniser and debouncer state
    logic [N_BTN-1:0]  s1_q;
    logic [N_BTN-1:0]  s2_q;
    logic [CNT_W-1:0]  cnt_q [N_BTN];
    logic [CNT_W-1:0]  cnt_d [N_BTN];
    logic [N_BTN-1:0]  level_q;
    logic [N_BTN-1:0]  level_d;
    logic [N_BTN-1:0]  press_q;
    logic [N_BTN-1:0]  press_d;

    // Pending set and event register
    logic [N_BTN-1:0]  pend_q;
    logic [N_BTN-1:0]  pend_d;
    logic              drop_q;
    logic              drop_d;
    evt_state_e        state_q;
    logic              evt_valid_q;
    logic [CODE_W-1:0] evt_code_q;

    logic              pend_any;
    logic [N_BTN-1:0]  low_mask;
    logic [CODE_W-1:0] low_idx;
    logic              load_en;
    logic [N_BTN-1:0]  load_clr;

    // -------------------------------------------------------------------------
    // Stability counters. A counter only runs while the synchronised input
    // differs from the current level; any return to the level clears it, so
    // the level flips only after STABLE_CYCLES consecutive differing samples.
    // -------------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // The pulse is taken from the next level so that it lands on the same
        // edge as the level change, not one cycle later.
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fixed-priority pick of the lowest pending button.
    // -------------------------------------------------------------------------
    always_comb begin
        low_mask = '0;
        low_idx  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_mask = '0;
                low_mask[i] = 1'b1;
                low_idx  = CODE_W'(i);
            end
        end
    end

    assign pend_any = |pend_q;

    // A load happens whenever something is pending and the event register is
    // free: either idle, or the current event is being accepted this edge.
    assign load_en  = pend_any && ((state_q == IDLE) || evt_ack);
    assign load_clr = load_en ? low_mask : '0;

    // The clear is applied before the set, so a press on the bit being loaded
    // in the same edge keeps the bit pending. A press on a bit that stays
    // pending merges into it and is flagged on evt_drop.
    always_comb begin
        pend_d = (pend_q & ~load_clr) | press_d;
        drop_d = |(press_d & pend_q & ~load_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Event register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_any) begin
                        state_q     <= HOLD;
                        evt_valid_q <= 1'b1;
                        evt_code_q  <= low_idx;
                    end
                end
                HOLD: begin
                    if (evt_ack) begin
                        if (pend_any) begin
                            evt_code_q <= low_idx;
                        end else begin
                            state_q     <= IDLE;
                            evt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_drop  = drop_q;

endmodule
